// File: rtl/mapa_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mapa_pkg
//  Purpose  : Shared cell codes, read-tag and FSM encodings, default map size
//  Revision : 1.0  initial release
// ============================================================================
package mapa_pkg;

    localparam int MAPA_WIDTH_DEF  = 40;
    localparam int MAPA_HEIGHT_DEF = 30;
    localparam int ADDR_W_DEF      = 11;

    localparam logic [1:0] CELL_VAZIO = 2'b00;
    localparam logic [1:0] CELL_COBRA = 2'b01;
    localparam logic [1:0] CELL_FRUTA = 2'b10;
    localparam logic [1:0] CELL_OBST  = 2'b11;

    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_VID  = 2'b01,
        TAG_A    = 2'b10,
        TAG_B    = 2'b11
    } rd_tag_t;

    typedef enum logic [0:0] {
        ST_SERVE = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mapa_port_arbiter_addr_calc.sv
`default_nettype none
// ============================================================================
//  Module   : mapa_addr_calc
//  Purpose  : Cell coordinate to linear RAM address, with range check
//  Revision : 1.0  initial release
// ============================================================================
module mapa_addr_calc #(
    parameter int MAPA_WIDTH  = 40,
    parameter int MAPA_HEIGHT = 30,
    parameter int ADDR_W      = 11
) (
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    always_comb begin
        in_range = (32'(x) < 32'(MAPA_WIDTH)) && (32'(y) < 32'(MAPA_HEIGHT));
        // Off-map cells are parked at address 0; callers suppress writes and zero read data.
        addr     = in_range ? ADDR_W'(32'(y) * 32'(MAPA_WIDTH) + 32'(x)) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/mapa_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mapa_port_arbiter
//  Purpose  : Owns the map RAM port; video > clear sweep > A/B round-robin
//  Revision : 1.0  initial release
// ============================================================================
module mapa_port_arbiter
    import mapa_pkg::*;
#(
    parameter int MAPA_WIDTH  = MAPA_WIDTH_DEF,
    parameter int MAPA_HEIGHT = MAPA_HEIGHT_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_ren,
    input  logic [9:0]        vid_x,
    input  logic [9:0]        vid_y,
    output logic [1:0]        vid_rdata,
    output logic              vid_rvalid,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [9:0]        a_x,
    input  logic [9:0]        a_y,
    input  logic [1:0]        a_wdata,
    output logic              a_gnt,
    output logic [1:0]        a_rdata,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [9:0]        b_x,
    input  logic [9:0]        b_y,
    input  logic [1:0]        b_wdata,
    output logic              b_gnt,
    output logic [1:0]        b_rdata,
    output logic              b_rvalid,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [1:0]        ram_wdata,
    input  logic [1:0]        ram_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAPA_WIDTH * MAPA_HEIGHT - 1);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ptr_q, ptr_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [1:0]        ram_wdata_q, ram_wdata_d;
    rd_tag_t           tag1_q, tag1_d, tag2_q;
    logic              zero1_q, zero1_d, zero2_q;

    logic              pick_vid, pick_clr, pick_a, pick_b;
    logic [9:0]        sel_x, sel_y;
    logic [ADDR_W-1:0] calc_addr;
    logic              calc_in_range;

    // ptr_q = 0 favours A, 1 favours B
    always_comb begin
        pick_vid = vid_ren;
        pick_clr = 1'b0;
        pick_a   = 1'b0;
        pick_b   = 1'b0;
        if (!vid_ren && !clear_start) begin
            if (state_q == ST_CLEAR) begin
                pick_clr = 1'b1;
            end else if (a_req && (!b_req || !ptr_q)) begin
                pick_a = 1'b1;
            end else if (b_req) begin
                pick_b = 1'b1;
            end
        end
    end

    always_comb begin
        sel_x = vid_x;
        sel_y = vid_y;
        if (pick_a) begin
            sel_x = a_x;
            sel_y = a_y;
        end else if (pick_b) begin
            sel_x = b_x;
            sel_y = b_y;
        end
    end

    mapa_addr_calc #(
        .MAPA_WIDTH  (MAPA_WIDTH),
        .MAPA_HEIGHT (MAPA_HEIGHT),
        .ADDR_W      (ADDR_W)
    ) u_addr_calc (
        .x        (sel_x),
        .y        (sel_y),
        .addr     (calc_addr),
        .in_range (calc_in_range)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ptr_d   = ptr_q;
        if (pick_a) begin
            ptr_d = 1'b1;
        end else if (pick_b) begin
            ptr_d = 1'b0;
        end
        case (state_q)
            ST_SERVE: begin
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (clear_start) begin
                    cnt_d = '0;
                end else if (pick_clr) begin
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_SERVE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = ST_SERVE;
        endcase
    end

    always_comb begin
        ram_addr_d  = '0;
        ram_we_d    = 1'b0;
        ram_wdata_d = CELL_VAZIO;
        tag1_d      = TAG_NONE;
        zero1_d     = 1'b0;
        if (pick_clr) begin
            ram_addr_d = cnt_q;
            ram_we_d   = 1'b1;
        end else if (pick_vid) begin
            ram_addr_d = calc_addr;
            tag1_d     = TAG_VID;
            zero1_d    = !calc_in_range;
        end else if (pick_a) begin
            ram_addr_d = calc_addr;
            if (a_we) begin
                ram_we_d    = calc_in_range;
                ram_wdata_d = calc_in_range ? a_wdata : CELL_VAZIO;
            end else begin
                tag1_d  = TAG_A;
                zero1_d = !calc_in_range;
            end
        end else if (pick_b) begin
            ram_addr_d = calc_addr;
            if (b_we) begin
                ram_we_d    = calc_in_range;
                ram_wdata_d = calc_in_range ? b_wdata : CELL_VAZIO;
            end else begin
                tag1_d  = TAG_B;
                zero1_d = !calc_in_range;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SERVE;
            cnt_q       <= '0;
            ptr_q       <= 1'b0;
            done_q      <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= CELL_VAZIO;
            tag1_q      <= TAG_NONE;
            tag2_q      <= TAG_NONE;
            zero1_q     <= 1'b0;
            zero2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            done_q      <= done_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag1_q;
            zero1_q     <= zero1_d;
            zero2_q     <= zero1_q;
        end
    end

    // Grants are combinational, so mask them while reset holds the block idle.
    assign a_gnt      = pick_a & ~reset;
    assign b_gnt      = pick_b & ~reset;

    assign vid_rvalid = (tag2_q == TAG_VID);
    assign a_rvalid   = (tag2_q == TAG_A);
    assign b_rvalid   = (tag2_q == TAG_B);
    assign vid_rdata  = (vid_rvalid && !zero2_q) ? ram_rdata : CELL_VAZIO;
    assign a_rdata    = (a_rvalid   && !zero2_q) ? ram_rdata : CELL_VAZIO;
    assign b_rdata    = (b_rvalid   && !zero2_q) ? ram_rdata : CELL_VAZIO;

    assign clear_busy = (state_q == ST_CLEAR);
    assign clear_done = done_q;
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mapa_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mapa_port_arbiter
//  Purpose  : Self-checking bench with a cell-level reference model and RAM
//  Revision : 1.0  initial release
// ============================================================================
module tb_mapa_port_arbiter;

    localparam int W     = 40;
    localparam int H     = 30;
    localparam int AW    = 11;
    localparam int NCELL = W * H;

    localparam int WHO_NONE = 0;
    localparam int WHO_VID  = 1;
    localparam int WHO_CLR  = 2;
    localparam int WHO_A    = 3;
    localparam int WHO_B    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          vid_ren;
    logic [9:0]    vid_x, vid_y;
    logic [1:0]    vid_rdata;
    logic          vid_rvalid;
    logic          a_req, a_we, b_req, b_we;
    logic [9:0]    a_x, a_y, b_x, b_y;
    logic [1:0]    a_wdata, b_wdata, a_rdata, b_rdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic          clear_start, clear_busy, clear_done;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [1:0]    ram_wdata;
    logic [1:0]    ram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mapa_port_arbiter #(
        .MAPA_WIDTH  (W),
        .MAPA_HEIGHT (H),
        .ADDR_W      (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vid_ren     (vid_ren),
        .vid_x       (vid_x),
        .vid_y       (vid_y),
        .vid_rdata   (vid_rdata),
        .vid_rvalid  (vid_rvalid),
        .a_req       (a_req),
        .a_we        (a_we),
        .a_x         (a_x),
        .a_y         (a_y),
        .a_wdata     (a_wdata),
        .a_gnt       (a_gnt),
        .a_rdata     (a_rdata),
        .a_rvalid    (a_rvalid),
        .b_req       (b_req),
        .b_we        (b_we),
        .b_x         (b_x),
        .b_y         (b_y),
        .b_wdata     (b_wdata),
        .b_gnt       (b_gnt),
        .b_rdata     (b_rdata),
        .b_rvalid    (b_rvalid),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fillval(input int i);
        return 2'((i * 13 + (i >> 5)) % 4);
    endfunction

    // ---------------- synchronous single-port RAM with backdoor ----------------
    logic [1:0]    mem [0:2047];
    logic          bd_fill = 1'b0;
    logic          bd_we   = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [1:0]    bd_data = '0;

    always @(posedge clk) begin
        if (bd_fill) begin
            for (int i = 0; i < 2048; i++) mem[i] <= fillval(i);
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    // ---------------- reference model: map contents + per-cycle expectations ----
    typedef struct packed {
        logic        we;
        logic        addr_care;
        logic [31:0] addr;
        logic [1:0]  wdata;
    } ram_exp_t;

    typedef struct packed {
        logic [2:0] who;
        logic [1:0] data;
    } rd_exp_t;

    logic [1:0] ref_map [0:2047];
    bit         m_clear = 0;
    int         m_cnt   = 0;
    bit         m_ptr   = 0;
    bit         m_done  = 0;
    ram_exp_t   m_ram   = '0;
    rd_exp_t    m_pipe0 = '0;
    rd_exp_t    m_pipe1 = '0;
    bit         pend_we = 0;
    int         pend_addr = 0;
    logic [1:0] pend_data = '0;
    int         last_who = WHO_NONE;

    int         m_who;
    bit         m_inr;
    int         m_addr;
    bit         m_nx_done;
    ram_exp_t   m_nram;
    rd_exp_t    m_nrd;

    always @(negedge clk) begin
        if (bd_fill) for (int i = 0; i < 2048; i++) ref_map[i] = fillval(i);
        if (bd_we) ref_map[bd_addr] = bd_data;
        if (reset) begin
            chk("reset_outputs", 32'({a_gnt, b_gnt, vid_rvalid, a_rvalid, b_rvalid,
                                      vid_rdata, a_rdata, b_rdata, clear_busy, clear_done,
                                      ram_addr, ram_we, ram_wdata}), 32'd0);
            m_clear = 0; m_cnt = 0; m_ptr = 0; m_done = 0;
            m_ram = '0; m_pipe0 = '0; m_pipe1 = '0;
            pend_we = 0; last_who = WHO_NONE;
        end else begin
            if (vid_ren)            m_who = WHO_VID;
            else if (clear_start)   m_who = WHO_NONE;
            else if (m_clear)       m_who = WHO_CLR;
            else if (a_req && b_req) m_who = m_ptr ? WHO_B : WHO_A;
            else if (a_req)         m_who = WHO_A;
            else if (b_req)         m_who = WHO_B;
            else                    m_who = WHO_NONE;

            chk("a_gnt", 32'(a_gnt), 32'(m_who == WHO_A));
            chk("b_gnt", 32'(b_gnt), 32'(m_who == WHO_B));
            chk("ram_we", 32'(ram_we), 32'(m_ram.we));
            if (m_ram.addr_care) chk("ram_addr", 32'(ram_addr), m_ram.addr);
            if (m_ram.we) chk("ram_wdata", 32'(ram_wdata), 32'(m_ram.wdata));
            chk("vid_rvalid", 32'(vid_rvalid), 32'(m_pipe1.who == 3'(WHO_VID)));
            chk("a_rvalid", 32'(a_rvalid), 32'(m_pipe1.who == 3'(WHO_A)));
            chk("b_rvalid", 32'(b_rvalid), 32'(m_pipe1.who == 3'(WHO_B)));
            if (m_pipe1.who == 3'(WHO_VID)) chk("vid_rdata", 32'(vid_rdata), 32'(m_pipe1.data));
            if (m_pipe1.who == 3'(WHO_A))   chk("a_rdata", 32'(a_rdata), 32'(m_pipe1.data));
            if (m_pipe1.who == 3'(WHO_B))   chk("b_rdata", 32'(b_rdata), 32'(m_pipe1.data));
            chk("clear_busy", 32'(clear_busy), 32'(m_clear));
            chk("clear_done", 32'(clear_done), 32'(m_done));

            if (pend_we) ref_map[pend_addr] = pend_data;
            pend_we   = 0;
            m_nram    = '0;
            m_nrd     = '0;
            m_nx_done = 0;
            case (m_who)
                WHO_CLR: begin
                    m_nram = '{we: 1'b1, addr_care: 1'b1, addr: 32'(m_cnt), wdata: 2'b00};
                    pend_we = 1; pend_addr = m_cnt; pend_data = 2'b00;
                    if (m_cnt == NCELL - 1) begin
                        m_clear = 0; m_nx_done = 1; m_cnt = 0;
                    end else begin
                        m_cnt++;
                    end
                end
                WHO_VID: begin
                    m_inr  = (int'(vid_x) < W) && (int'(vid_y) < H);
                    m_addr = int'(vid_y) * W + int'(vid_x);
                    m_nram.addr_care = m_inr;
                    m_nram.addr      = 32'(m_addr);
                    m_nrd = '{who: 3'(WHO_VID), data: m_inr ? ref_map[m_addr] : 2'b00};
                end
                WHO_A, WHO_B: begin
                    if (m_who == WHO_A) begin
                        m_inr  = (int'(a_x) < W) && (int'(a_y) < H);
                        m_addr = int'(a_y) * W + int'(a_x);
                    end else begin
                        m_inr  = (int'(b_x) < W) && (int'(b_y) < H);
                        m_addr = int'(b_y) * W + int'(b_x);
                    end
                    m_nram.addr_care = m_inr;
                    m_nram.addr      = 32'(m_addr);
                    if ((m_who == WHO_A) ? a_we : b_we) begin
                        m_nram.we    = m_inr;
                        m_nram.wdata = (m_who == WHO_A) ? a_wdata : b_wdata;
                        if (m_inr) begin
                            pend_we = 1; pend_addr = m_addr; pend_data = m_nram.wdata;
                        end
                    end else begin
                        m_nrd = '{who: 3'(m_who), data: m_inr ? ref_map[m_addr] : 2'b00};
                    end
                    m_ptr = (m_who == WHO_A);
                end
                default: ;
            endcase
            if (clear_start) begin
                m_clear = 1; m_cnt = 0;
            end
            m_ram    = m_nram;
            m_pipe1  = m_pipe0;
            m_pipe0  = m_nrd;
            m_done   = m_nx_done;
            last_who = m_who;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [9:0] rcoord(input int lim);
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 10)      return 10'(lim + int'($urandom_range(0, 30)));
        else if (r < 50) return 10'($urandom_range(0, 3));
        else             return 10'($urandom_range(0, lim - 1));
    endfunction

    int  busy_cnt, done_seen, gnt_in_busy, nonzero;
    bit  done_hit;

    initial begin
        reset = 1'b1; vid_ren = 0; vid_x = 0; vid_y = 0;
        a_req = 0; a_we = 0; a_x = 0; a_y = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_x = 0; b_y = 0; b_wdata = 0;
        clear_start = 0;
        tick(); bd_fill = 1'b1;
        tick(); bd_fill = 1'b0;
        #1 chk("reset_state", 32'({a_gnt, b_gnt, clear_busy, clear_done, ram_we, ram_addr}), 32'd0);
        tick(); reset = 1'b0;

        // single write by A at (3,2)
        tick(); a_req = 1; a_we = 1; a_x = 3; a_y = 2; a_wdata = 2'b01;
        #1 chk("t1_gnt", 32'(a_gnt), 32'd1);
        tick(); a_req = 0;
        #1 chk("t1_addr", 32'(ram_addr), 32'd83);
        chk("t1_we", 32'(ram_we), 32'd1);
        chk("t1_wdata", 32'(ram_wdata), 32'd1);

        // continuous video starves clients; then A/B alternate from A
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        tick(); vid_ren = 1; a_req = 1; a_we = 0; a_x = 1; a_y = 1;
        b_req = 1; b_we = 0; b_x = 2; b_y = 2;
        for (int i = 0; i < 8; i++) begin
            vid_x = rcoord(W); vid_y = rcoord(H);
            #1 chk("t2_no_gnt", 32'({a_gnt, b_gnt}), 32'd0);
            tick();
        end
        vid_ren = 0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t2_alternate", 32'({a_gnt, b_gnt}), (i % 2 == 0) ? 32'd2 : 32'd1);
            tick();
        end
        a_req = 0; b_req = 0;

        // B reads the last cell
        tick(); bd_we = 1; bd_addr = 11'd1199; bd_data = 2'b11;
        tick(); bd_we = 0; b_req = 1; b_we = 0; b_x = 39; b_y = 29;
        #1 chk("t3_gnt", 32'(b_gnt), 32'd1);
        tick(); b_req = 0;
        #1 chk("t3_addr", 32'(ram_addr), 32'd1199);
        tick();
        #1 chk("t3_b_rvalid", 32'(b_rvalid), 32'd1);
        chk("t3_b_rdata", 32'(b_rdata), 32'd3);
        chk("t3_a_rvalid", 32'(a_rvalid), 32'd0);

        // full clear sweep with A waiting
        tick(); clear_start = 1; a_req = 1; a_we = 1; a_x = 5; a_y = 5; a_wdata = 2'b10;
        #1 chk("t4_start_no_gnt", 32'(a_gnt), 32'd0);
        tick(); clear_start = 0;
        busy_cnt = 0; done_seen = 0; gnt_in_busy = 0; done_hit = 0;
        for (int c = 0; c < 1300 && !done_hit; c++) begin
            #1;
            if (clear_busy) busy_cnt++;
            if (clear_busy && a_gnt) gnt_in_busy++;
            if (clear_done) begin
                done_seen++; done_hit = 1;
                chk("t4_gnt_after_sweep", 32'(a_gnt), 32'd1);
            end
            if (!done_hit) tick();
        end
        chk("t4_done_seen", 32'(done_seen), 32'd1);
        chk("t4_busy_cycles", 32'(busy_cnt), 32'd1200);
        chk("t4_gnt_in_busy", 32'(gnt_in_busy), 32'd0);
        tick(); a_req = 0;
        repeat (3) tick();
        nonzero = 0;
        for (int i = 0; i < NCELL; i++) if (i != 205 && mem[i] != 2'b00) nonzero++;
        chk("t4_cells_cleared", 32'(nonzero), 32'd0);
        chk("t4_a_write", 32'(mem[205]), 32'd2);

        // out-of-range coordinates
        tick(); bd_we = 1; bd_addr = 11'd1200; bd_data = 2'b11;
        tick(); bd_addr = 11'd0;
        tick(); bd_we = 0; a_req = 1; a_we = 1; a_x = 40; a_y = 5; a_wdata = 2'b11;
        #1 chk("t5_wr_gnt", 32'(a_gnt), 32'd1);
        tick(); a_we = 0; a_x = 0; a_y = 30;
        #1 chk("t5_wr_no_we", 32'(ram_we), 32'd0);
        chk("t5_rd_gnt", 32'(a_gnt), 32'd1);
        tick(); a_req = 0;
        tick();
        #1 chk("t5_rd_rvalid", 32'(a_rvalid), 32'd1);
        chk("t5_rd_rdata", 32'(a_rdata), 32'd0);

        // reset during a sweep with a video read in flight
        tick(); clear_start = 1;
        tick(); clear_start = 0;
        repeat (20) tick();
        vid_ren = 1; vid_x = 1; vid_y = 1;
        tick(); vid_ren = 0; reset = 1;
        #1 chk("t6_outputs_zero", 32'({a_gnt, b_gnt, vid_rvalid, a_rvalid, b_rvalid,
                                       clear_busy, clear_done, ram_we, ram_addr, ram_wdata}), 32'd0);
        tick(); reset = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            #1 chk("t6_quiet", 32'({vid_rvalid, a_rvalid, b_rvalid, clear_done, clear_busy}), 32'd0);
        end
        tick(); clear_start = 1;
        tick(); clear_start = 0;
        #1 chk("t6_busy", 32'(clear_busy), 32'd1);
        tick();
        #1 chk("t6_restart_addr", 32'(ram_addr), 32'd0);
        chk("t6_restart_we", 32'(ram_we), 32'd1);
        done_hit = 0;
        for (int c = 0; c < 1300 && !done_hit; c++) begin
            tick();
            #1 if (clear_done) done_hit = 1;
        end
        chk("t6_sweep_done", 32'(done_hit), 32'd1);

        // randomized traffic against the model
        for (int c = 0; c < 5000; c++) begin
            tick();
            vid_ren = ($urandom_range(0, 99) < 30);
            vid_x = rcoord(W); vid_y = rcoord(H);
            clear_start = ($urandom_range(0, 1999) == 0);
            if (a_req && last_who == WHO_A) a_req = 0;
            if (b_req && last_who == WHO_B) b_req = 0;
            if (!a_req && $urandom_range(0, 2) == 0) begin
                a_req = 1; a_we = 1'($urandom); a_x = rcoord(W); a_y = rcoord(H);
                a_wdata = 2'($urandom);
            end
            if (!b_req && $urandom_range(0, 2) == 0) begin
                b_req = 1; b_we = 1'($urandom); b_x = rcoord(W); b_y = rcoord(H);
                b_wdata = 2'($urandom);
            end
        end
        tick(); vid_ren = 0; a_req = 0; b_req = 0; clear_start = 0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
